// File: rtl/exit_status_reporter.sv
// Latches the first program exit from x_heep_system and reports it on an LED:
// solid on for pass, repeating blink code (count = exit code, clamped) for fail.
// Optional PS GPIO request/ack handshake is built when EXIT_STATUS_PS_EN is defined.
module exit_status_reporter #(
  parameter int unsigned BLINK_HALF_PERIOD = 12500000,
  parameter int unsigned PAUSE_HALVES      = 4,
  parameter int unsigned MAX_BLINKS        = 15
) (
  input  logic        clk_gen,
  input  logic        rst_n,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  input  logic        clear_i,
`ifdef EXIT_STATUS_PS_EN
  input  logic        ps_ack_i,
  output logic        ps_req_o,
`endif
  output logic        status_led_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [31:0] exit_code_o
);

  localparam int unsigned TW = $clog2(BLINK_HALF_PERIOD + 1);
  localparam int unsigned PW = $clog2(PAUSE_HALVES + 1);
  localparam int unsigned BW = $clog2(MAX_BLINKS + 1);

  localparam logic [TW-1:0] T_LAST = TW'(BLINK_HALF_PERIOD - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PAUSE_HALVES - 1);
  localparam logic [BW-1:0] B_MAX  = BW'(MAX_BLINKS);

  typedef enum logic [2:0] {
    IDLE,
    PASS,
    BLINK_ON,
    BLINK_OFF,
    PAUSE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] halves_q, halves_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [BW-1:0] blink_n_q, blink_n_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [31:0]   code_q, code_d;
  logic          led_q, led_d;
  logic          exit_valid_q;
  logic          capture;

  // clear_i takes priority, so a coincident rising edge is not a capture
  assign capture = exit_valid_i & ~exit_valid_q & (state_q == IDLE) & ~clear_i;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    halves_d    = halves_q;
    blink_cnt_d = blink_cnt_q;
    blink_n_d   = blink_n_q;
    done_d      = done_q;
    pass_d      = pass_q;
    code_d      = code_q;

    if (clear_i) begin
      state_d     = IDLE;
      timer_d     = '0;
      halves_d    = '0;
      blink_cnt_d = '0;
      blink_n_d   = '0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      code_d      = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (capture) begin
            code_d      = exit_value_i;
            done_d      = 1'b1;
            pass_d      = (exit_value_i == '0);
            blink_n_d   = (exit_value_i > 32'(MAX_BLINKS)) ? B_MAX : exit_value_i[BW-1:0];
            timer_d     = '0;
            halves_d    = '0;
            blink_cnt_d = '0;
            state_d     = (exit_value_i == '0) ? PASS : BLINK_ON;
          end
        end
        PASS: ;
        BLINK_ON: begin
          if (timer_q == T_LAST) begin
            timer_d     = '0;
            blink_cnt_d = blink_cnt_q + 1'b1;
            state_d     = BLINK_OFF;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        BLINK_OFF: begin
          if (timer_q == T_LAST) begin
            timer_d = '0;
            if (blink_cnt_q == blink_n_q) begin
              blink_cnt_d = '0;
              halves_d    = '0;
              state_d     = PAUSE;
            end else begin
              state_d = BLINK_ON;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        PAUSE: begin
          if (timer_q == T_LAST) begin
            timer_d = '0;
            if (halves_q == P_LAST) begin
              halves_d = '0;
              state_d  = BLINK_ON;
            end else begin
              halves_d = halves_q + 1'b1;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // LED follows the next state so it switches on the same edge as the FSM
    led_d = (state_d == PASS) || (state_d == BLINK_ON);
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      halves_q     <= '0;
      blink_cnt_q  <= '0;
      blink_n_q    <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      code_q       <= '0;
      led_q        <= 1'b0;
      exit_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      halves_q     <= halves_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_n_q    <= blink_n_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      code_q       <= code_d;
      led_q        <= led_d;
      exit_valid_q <= exit_valid_i;
    end
  end

  assign status_led_o = led_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign exit_code_o  = code_q;

`ifdef EXIT_STATUS_PS_EN
  logic ps_req_q;
  logic ps_pend_q;

  // A capture seen while ack is still high is parked until ack drops
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      ps_req_q  <= 1'b0;
      ps_pend_q <= 1'b0;
    end else if (clear_i) begin
      ps_req_q  <= 1'b0;
      ps_pend_q <= 1'b0;
    end else if (ps_req_q && ps_ack_i) begin
      ps_req_q <= 1'b0;
    end else if (capture || ps_pend_q) begin
      if (!ps_ack_i) begin
        ps_req_q  <= 1'b1;
        ps_pend_q <= 1'b0;
      end else begin
        ps_pend_q <= 1'b1;
      end
    end
  end

  assign ps_req_o = ps_req_q;
`endif

endmodule

// File: tb/tb_exit_status_reporter.sv
// Self-checking bench for exit_status_reporter: directed scenarios plus random
// exit codes and input noise, checked against a cycle-offset LED pattern model.
module tb_exit_status_reporter;

  localparam int unsigned BHP = 4;
  localparam int unsigned PH  = 2;
  localparam int unsigned MB  = 15;

  logic        clk_gen      = 1'b0;
  logic        rst_n        = 1'b0;
  logic        exit_valid_i = 1'b0;
  logic [31:0] exit_value_i = '0;
  logic        clear_i      = 1'b0;
  logic        status_led_o;
  logic        done_o;
  logic        pass_o;
  logic [31:0] exit_code_o;
`ifdef EXIT_STATUS_PS_EN
  logic        ps_ack_i = 1'b0;
  logic        ps_req_o;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: latched code plus cycles elapsed since capture
  bit          m_evq;
  bit          m_latched;
  logic [31:0] m_code;
  int unsigned m_k;
`ifdef EXIT_STATUS_PS_EN
  bit          m_req;
  bit          m_pend;
`endif

  exit_status_reporter #(
    .BLINK_HALF_PERIOD(BHP),
    .PAUSE_HALVES     (PH),
    .MAX_BLINKS       (MB)
  ) dut (
    .clk_gen     (clk_gen),
    .rst_n       (rst_n),
    .exit_valid_i(exit_valid_i),
    .exit_value_i(exit_value_i),
    .clear_i     (clear_i),
`ifdef EXIT_STATUS_PS_EN
    .ps_ack_i    (ps_ack_i),
    .ps_req_o    (ps_req_o),
`endif
    .status_led_o(status_led_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .exit_code_o (exit_code_o)
  );

  always #5 clk_gen = ~clk_gen;

  function automatic logic exp_led();
    int unsigned b, p, pos;
    if (!m_latched) return 1'b0;
    if (m_code == 0) return 1'b1;
    b   = (m_code > MB) ? MB : m_code;
    p   = b * 2 * BHP + PH * BHP;
    pos = m_k % p;
    return (pos < b * 2 * BHP) && ((pos % (2 * BHP)) < BHP);
  endfunction

  task automatic model_reset();
    m_evq     = 1'b0;
    m_latched = 1'b0;
    m_code    = '0;
    m_k       = 0;
`ifdef EXIT_STATUS_PS_EN
    m_req     = 1'b0;
    m_pend    = 1'b0;
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".done"}, {31'b0, done_o}, {31'b0, m_latched});
    chk({tag, ".pass"}, {31'b0, pass_o}, {31'b0, m_latched && (m_code == 0)});
    chk({tag, ".code"}, exit_code_o, m_latched ? m_code : 32'h0);
    chk({tag, ".led"}, {31'b0, status_led_o}, {31'b0, exp_led()});
`ifdef EXIT_STATUS_PS_EN
    chk({tag, ".req"}, {31'b0, ps_req_o}, {31'b0, m_req});
`endif
  endtask

  // Advance one clock; model applies the inputs that were present at the edge
  task automatic tick();
    bit          ev, clr, cap;
    logic [31:0] val;
`ifdef EXIT_STATUS_PS_EN
    bit          ack;
    ack = ps_ack_i;
`endif
    ev  = exit_valid_i;
    clr = clear_i;
    val = exit_value_i;
    @(posedge clk_gen);
    if (!rst_n) begin
      model_reset();
    end else begin
      cap = ev && !m_evq && !m_latched && !clr;
      if (clr) begin
        m_latched = 1'b0;
        m_code    = '0;
        m_k       = 0;
      end else if (cap) begin
        m_latched = 1'b1;
        m_code    = val;
        m_k       = 0;
      end else if (m_latched) begin
        m_k++;
      end
`ifdef EXIT_STATUS_PS_EN
      if (clr) begin
        m_req  = 1'b0;
        m_pend = 1'b0;
      end else if (m_req && ack) begin
        m_req = 1'b0;
      end else if (cap || m_pend) begin
        if (!ack) begin
          m_req  = 1'b1;
          m_pend = 1'b0;
        end else begin
          m_pend = 1'b1;
        end
      end
`endif
      m_evq = ev;
    end
    #1;
  endtask

  task automatic run(input int n, input bit noise, input string tag);
    for (int i = 0; i < n; i++) begin
      if (noise) begin
        exit_valid_i = 1'($urandom_range(0, 1));
        exit_value_i = $urandom;
      end
      tick();
      chk_all(tag);
    end
  endtask

  task automatic capture(input logic [31:0] value);
    exit_valid_i = 1'b0;
    tick();
    exit_value_i = value;
    exit_valid_i = 1'b1;
    tick();
    exit_valid_i = 1'b0;
  endtask

  task automatic do_clear();
    exit_valid_i = 1'b0;
    clear_i      = 1'b1;
    tick();
    clear_i = 1'b0;
    chk_all("clear");
  endtask

  initial begin
    logic [31:0] val;
    model_reset();

    // Reset state
    #3;
    chk_all("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_all("post_reset");

    // Pass: solid LED held regardless of later exit_valid activity
    capture(32'h0);
    chk("pass.done", {31'b0, done_o}, 32'h1);
    chk("pass.pass", {31'b0, pass_o}, 32'h1);
    chk("pass.led", {31'b0, status_led_o}, 32'h1);
    run(100, 1'b1, "pass.hold");
    do_clear();

    // Fail code 3: two full 32-cycle periods, then ignore a second exit
    capture(32'd3);
    chk("code3.code", exit_code_o, 32'd3);
    chk("code3.pass", {31'b0, pass_o}, 32'h0);
    run(63, 1'b0, "code3");
    capture(32'd5);
    chk("ignore.code", exit_code_o, 32'd3);
    run(20, 1'b1, "code3.noise");

    // Clear mid-blink while exit_valid is held high: no recapture afterwards
    exit_valid_i = 1'b0;
    for (int i = 0; i < 64 && !exp_led(); i++) tick();
    chk("clear.in_on", {31'b0, status_led_o}, 32'h1);
    exit_valid_i = 1'b1;
    clear_i      = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clear.done", {31'b0, done_o}, 32'h0);
    chk("clear.led", {31'b0, status_led_o}, 32'h0);
    chk("clear.code", exit_code_o, 32'h0);
    run(10, 1'b0, "clear.held");
    exit_valid_i = 1'b0;

    // Clamp: 0x100 blinks 15 times, 128-cycle period
    capture(32'h100);
    chk("clamp.code", exit_code_o, 32'h100);
    run(255, 1'b0, "clamp");
    do_clear();

    // Simultaneous clear and rising edge: no capture; held high stays ignored
    exit_value_i = 32'd7;
    exit_valid_i = 1'b1;
    clear_i      = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("simul.done", {31'b0, done_o}, 32'h0);
    run(6, 1'b0, "simul.held");
    exit_valid_i = 1'b0;

    // Random exit codes with input noise, cleared at a random point
    for (int i = 0; i < 6; i++) begin
      val = (i % 2 == 1) ? 32'($urandom_range(1, 20)) : $urandom;
      capture(val);
      chk("rand.code", exit_code_o, val);
      run(int'($urandom_range(10, 80)), 1'b1, "rand");
      do_clear();
    end

    // Asynchronous reset in the middle of the pause
    capture(32'd3);
    run(26, 1'b0, "pre_async");
    chk("async.pause_led", {31'b0, status_led_o}, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async.done", {31'b0, done_o}, 32'h0);
    chk("async.code", exit_code_o, 32'h0);
    chk_all("async");
    tick();
    rst_n = 1'b1;
    tick();
    chk_all("async.release");

`ifdef EXIT_STATUS_PS_EN
    // Handshake: request with done, drops once ack is sampled, no re-raise
    capture(32'd2);
    chk("ps.req_raise", {31'b0, ps_req_o}, 32'h1);
    chk("ps.done", {31'b0, done_o}, 32'h1);
    ps_ack_i = 1'b1;
    tick();
    chk("ps.req_drop", {31'b0, ps_req_o}, 32'h0);
    run(2, 1'b0, "ps.ack_high");
    ps_ack_i = 1'b0;
    run(4, 1'b0, "ps.ack_low");
    do_clear();
    ps_ack_i = 1'b1;
    capture(32'd4);
    chk("ps.held_off", {31'b0, ps_req_o}, 32'h0);
    ps_ack_i = 1'b0;
    tick();
    chk("ps.late_raise", {31'b0, ps_req_o}, 32'h1);
    run(3, 1'b0, "ps.late");
    do_clear();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exit_status_reporter.md
Name: exit_status_reporter

Overview:
- Sits directly downstream of the x_heep_system instance in the FPGA top wrapper.
- Consumes exit_valid_o and the full 32-bit exit_value_o, and latches the first program exit.
- Reports the result on a board LED: solid on for pass; a repeating blink code for failure, where the number of blinks equals the exit code.
- Gives FPGA bring-up a visible pass/fail indication without JTAG or UART.

Parameters:
- BLINK_HALF_PERIOD, 12500000, clk_gen cycles per LED on-phase and per off-phase; must be >= 1.
- PAUSE_HALVES, 4, number of half-periods the LED stays off between blink-code repetitions; must be >= 1.
- MAX_BLINKS, 15, upper clamp on the blink count; must be >= 1.

Ports:
- clk_gen  input  1  system clock, same clock that drives x_heep_system.
- rst_n  input  1  reset, asynchronous, active-low.
- exit_valid_i  input  1  exit_valid from x_heep_system, synchronous to clk_gen.
- exit_value_i  input  32  exit_value from x_heep_system.
- clear_i  input  1  synchronous clear of the latched state (single-cycle or level).
- status_led_o  output  1  LED drive.
- done_o  output  1  an exit has been latched.
- pass_o  output  1  the latched exit code was 0.
- exit_code_o  output  32  the latched exit_value.

Behaviour:
- Reset values: status_led_o=0, done_o=0, pass_o=0, exit_code_o=0; FSM in IDLE; all counters 0; exit_valid_q=0.
- Edge detection:
  - exit_valid_q is a registered copy of exit_valid_i.
  - capture = exit_valid_i & ~exit_valid_q & (state==IDLE).
- Capture:
  - On the capture cycle, exit_code_o <= exit_value_i and done_o <= 1.
  - pass_o <= (exit_value_i==0).
  - blink_n <= min(exit_value_i, MAX_BLINKS), compared as unsigned 32-bit.
  - Outputs update 1 cycle after exit_valid_i first rises.
- FSM states: IDLE, PASS, BLINK_ON, BLINK_OFF, PAUSE.
- IDLE:
  - LED=0.
  - On capture with value 0 -> PASS.
  - On capture with nonzero value -> BLINK_ON, with blink counter=0 and half-period timer=0.
- PASS: LED=1 and held; stays in PASS until clear_i.
- BLINK_ON:
  - LED=1 for exactly BLINK_HALF_PERIOD cycles.
  - Then -> BLINK_OFF, blink counter +1.
- BLINK_OFF:
  - LED=0 for BLINK_HALF_PERIOD cycles.
  - Then, if blink counter==blink_n -> PAUSE (counter reset to 0); else -> BLINK_ON.
- PAUSE:
  - LED=0 for PAUSE_HALVES*BLINK_HALF_PERIOD cycles.
  - Then -> BLINK_ON; the sequence repeats indefinitely.
- Timer:
  - Counts 0..BLINK_HALF_PERIOD-1.
  - Width is $clog2(BLINK_HALF_PERIOD+1); the pause-halves counter has width $clog2(PAUSE_HALVES+1).
  - No wrap beyond the terminal value; the timer is reset on every state change.
- status_led_o is registered and changes on the same clock edge as the state.
- Only the first exit is latched. Later exit_valid edges are ignored until clear_i.
- clear_i:
  - Returns the block to IDLE and zeroes done_o, pass_o, exit_code_o and the LED on the next edge, from any state, including mid-blink.
  - clear_i has priority over a simultaneous capture.
- exit_valid_i held high across a clear does not recapture, because exit_valid_q is still 1. A fresh 0->1 edge is required.
- Exit codes above MAX_BLINKS blink MAX_BLINKS times; exit_code_o still holds the full value.
- Asynchronous reset mid-sequence drops all outputs to 0 immediately.

Optional Feature:
- Macro: EXIT_STATUS_PS_EN.
- When defined, two ports are added: ps_req_o (output, 1) and ps_ack_i (input, 1). They form a 4-phase handshake toward the PS GPIO block.
  - ps_req_o goes to 1 on the cycle done_o goes to 1.
  - ps_req_o holds until ps_ack_i is sampled 1, then drops to 0 on the next edge.
  - A new request is never raised while ps_ack_i is still 1.
  - clear_i forces ps_req_o=0.
  - Reset value of ps_req_o is 0.
- When undefined, the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Common settings: BLINK_HALF_PERIOD=4, PAUSE_HALVES=2, MAX_BLINKS=15.
- Pass case: reset, then pulse exit_valid_i with value 0 -> 1 cycle later done_o=1, pass_o=1, exit_code_o=0, LED=1; LED stays 1 for 100 cycles.
- Fail code 3: value 3 -> LED pattern 1111 0000 repeated 3 times, then 8 cycles of 0, then the pattern repeats; period 32 cycles; pass_o=0, exit_code_o=3.
- Clamp: value 0x100 -> 15 blinks per period (period 15*8+8 = 128 cycles); exit_code_o=0x100.
- Ignore and clear:
  - A second exit_valid edge with value 5 after latching 3 -> exit_code_o stays 3.
  - clear_i mid BLINK_ON -> next cycle all outputs 0 and state IDLE.
  - With exit_valid_i held high through the clear -> no recapture.
- Simultaneous: clear_i and the exit_valid_i rising edge in the same cycle -> no capture, done_o=0. Async rst_n low mid-PAUSE -> outputs 0 immediately.
- EXIT_STATUS_PS_EN:
  - Capture value 2 -> ps_req_o=1 together with done_o.
  - ps_ack_i=1 for 3 cycles -> ps_req_o drops 1 cycle after ack is first sampled.
  - No re-request while ack is high.
